lsu_stage: RTL

- Load/store unit directly downstream of ex_stage.
- Takes the memory operation computed by EX (address, store data, size) and drives the data-memory request/grant/rvalid interface.
- Aligns and sign- or zero-extends load data, then hands the result and destination register to wb_stage.
- Holds one outstanding transaction and tells hazard_control to stall the pipeline while it is busy.

---
 rtl/riscv_defines.sv | 24 ++
 rtl/lsu_load_align.sv | 29 ++
 rtl/lsu_stage.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/riscv_defines.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | riscv_defines : shared widths and encodings for the core pipeline   |
// | Revision      : 1.0                                                 |
// +--------------------------------------------------------------------+
package riscv_defines;

  localparam int WORD_WIDTH     = 32;
  localparam int REG_ADDR_WIDTH = 5;

  typedef enum logic [1:0] {
    LSU_BYTE = 2'd0,
    LSU_HALF = 2'd1,
    LSU_WORD = 2'd2
  } lsu_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } lsu_state_e;

endpackage
`default_nettype wire

// File: rtl/lsu_load_align.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lsu_load_align : extracts a byte/half/word from a read word and     |
// |                  sign- or zero-extends it                           |
// | Revision       : 1.0                                                |
// +--------------------------------------------------------------------+
module lsu_load_align
  import riscv_defines::*;
(
  input  logic [WORD_WIDTH-1:0] i_rdata,
  input  logic [1:0]            i_offset,
  input  logic [1:0]            i_size,
  input  logic                  i_unsigned,
  output logic [WORD_WIDTH-1:0] o_wdata
);

  logic [WORD_WIDTH-1:0] w_shifted;

  always_comb begin
    w_shifted = i_rdata >> {i_offset, 3'b000};
    case (lsu_size_e'(i_size))
      LSU_BYTE: o_wdata = {{(WORD_WIDTH-8){~i_unsigned & w_shifted[7]}}, w_shifted[7:0]};
      LSU_HALF: o_wdata = {{(WORD_WIDTH-16){~i_unsigned & w_shifted[15]}}, w_shifted[15:0]};
      default:  o_wdata = w_shifted;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lsu_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lsu_stage : single-outstanding load/store unit between EX and WB    |
// | Revision  : 1.0                                                     |
// +--------------------------------------------------------------------+
module lsu_stage
  import riscv_defines::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ex_valid_i,
  output logic                      ex_ready_o,
  input  logic                      ex_we_i,
  input  logic [1:0]                ex_size_i,
  input  logic                      ex_unsigned_i,
  input  logic [WORD_WIDTH-1:0]     ex_addr_i,
  input  logic [WORD_WIDTH-1:0]     ex_wdata_i,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd_i,
  output logic                      data_req_o,
  output logic [WORD_WIDTH-1:0]     data_addr_o,
  output logic                      data_we_o,
  output logic [3:0]                data_be_o,
  output logic [WORD_WIDTH-1:0]     data_wdata_o,
  input  logic [WORD_WIDTH-1:0]     data_rdata_i,
  input  logic                      data_rvalid_i,
  input  logic                      data_gnt_i,
  output logic                      wb_valid_o,
  output logic                      wb_we_o,
  output logic [REG_ADDR_WIDTH-1:0] wb_rd_o,
  output logic [WORD_WIDTH-1:0]     wb_data_o,
  output logic                      stall_o,
  output logic                      misalign_o
);

  lsu_state_e                r_state, w_state_next;
  lsu_size_e                 r_size, w_size;
  logic                      r_we, r_unsigned;
  logic [1:0]                r_off;
  logic [REG_ADDR_WIDTH-1:0] r_rd;
  logic [WORD_WIDTH-1:0]     r_addr, r_wdata;
  logic [3:0]                r_be;
  logic                      r_wb_valid, r_wb_we, r_misalign;
  logic [REG_ADDR_WIDTH-1:0] r_wb_rd;
  logic [WORD_WIDTH-1:0]     r_wb_data;

  logic                      w_misalign, w_accept, w_done;
  logic [3:0]                w_be;
  logic [WORD_WIDTH-1:0]     w_wdata, w_load_data;

  // Reserved size encoding 2'b11 behaves as a word access.
  always_comb begin
    w_size = (ex_size_i == 2'b11) ? LSU_WORD : lsu_size_e'(ex_size_i);
    w_be    = 4'b1111;
    w_wdata = ex_wdata_i;
    case (w_size)
      LSU_BYTE: begin
        w_be    = 4'b0001 << ex_addr_i[1:0];
        w_wdata = {4{ex_wdata_i[7:0]}};
      end
      LSU_HALF: begin
        w_be    = 4'b0011 << {ex_addr_i[1], 1'b0};
        w_wdata = {2{ex_wdata_i[15:0]}};
      end
      default: ;
    endcase
    w_misalign = ((w_size == LSU_HALF) && ex_addr_i[0]) ||
                 ((w_size == LSU_WORD) && (ex_addr_i[1:0] != 2'b00));
  end

  assign w_accept = (r_state == IDLE) && ex_valid_i && !w_misalign;
  assign w_done   = (r_state == WAIT) && data_rvalid_i;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept)   w_state_next = REQ;
      REQ:     if (data_gnt_i) w_state_next = WAIT;
      WAIT:    if (w_done)     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_size     <= LSU_BYTE;
      r_we       <= 1'b0;
      r_unsigned <= 1'b0;
      r_off      <= 2'b00;
      r_rd       <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_be       <= 4'b0000;
    end else if (w_accept) begin
      r_size     <= w_size;
      r_we       <= ex_we_i;
      r_unsigned <= ex_unsigned_i;
      r_off      <= ex_addr_i[1:0];
      r_rd       <= ex_rd_i;
      r_addr     <= {ex_addr_i[WORD_WIDTH-1:2], 2'b00};
      r_wdata    <= w_wdata;
      r_be       <= w_be;
    end
  end

  lsu_load_align u_load_align (
    .i_rdata    (data_rdata_i),
    .i_offset   (r_off),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .o_wdata    (w_load_data)
  );

  // Stores complete through the same path but never write the register file.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb_valid <= 1'b0;
      r_wb_we    <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
      r_misalign <= 1'b0;
    end else begin
      r_wb_valid <= w_done;
      r_wb_we    <= w_done && !r_we;
      r_misalign <= (r_state == IDLE) && ex_valid_i && w_misalign;
      if (w_done) begin
        r_wb_rd   <= r_rd;
        r_wb_data <= r_we ? '0 : w_load_data;
      end
    end
  end

  assign ex_ready_o   = (r_state == IDLE);
  assign stall_o      = ~ex_ready_o;
  assign data_req_o   = (r_state == REQ);
  assign data_addr_o  = r_addr;
  assign data_we_o    = r_we;
  assign data_be_o    = r_be;
  assign data_wdata_o = r_wdata;
  assign wb_valid_o   = r_wb_valid;
  assign wb_we_o      = r_wb_we;
  assign wb_rd_o      = r_wb_rd;
  assign wb_data_o    = r_wb_data;
  assign misalign_o   = r_misalign;

endmodule
`default_nettype wire
